fetch_sequencer: RTL

//  PC sequencer and instruction-fetch controller ahead of the decode/branch-resolution stage.

---
 rtl/fetch_pkg.sv | 23 ++
 rtl/fetch_sequencer_if.sv | 41 ++++
 rtl/fetch_sequencer_buf2.sv | 76 +++++++
 rtl/fetch_sequencer.sv | 139 +++++++++++++
 4 files changed

// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction-fetch slice.
//   state_e   : sequencer state (BOOT, RUN, HALTED)
//   INSTR_W   : instruction word width
//   PC_STEP   : byte increment between sequential fetches
//   NOP_INSTR : canonical no-op encoding (addi x0,x0,0)
//   sat_inc16 : saturating 16-bit increment
package fetch_pkg;

  typedef enum logic [1:0] {
    BOOT   = 2'd0,
    RUN    = 2'd1,
    HALTED = 2'd2
  } state_e;

  localparam int unsigned INSTR_W = 32;
  localparam int unsigned PC_STEP = 4;
  localparam logic [INSTR_W-1:0] NOP_INSTR = 32'h0000_0013;

  function automatic logic [15:0] sat_inc16(input logic [15:0] value);
    return (value == 16'hFFFF) ? value : value + 16'd1;
  endfunction

endpackage

// File: rtl/fetch_sequencer_if.sv
// Bus bundle between the fetch sequencer, instruction memory and the core.
//   imem_req_valid/ready/addr : request channel to instruction memory
//   imem_rsp_valid/data       : in-order response channel, no back-pressure
//   instr_valid/instr/instr_pc: held instruction presented to the core
//   instr_ack/redirect/_pc    : core consume strobe and retire-time redirect
//   halt                      : level request to stop issuing fetches
//   redirect_cnt              : saturating count of accepted redirects
// master = sequencer side, slave = memory/core side.
interface fetch_sequencer_if
  import fetch_pkg::*;
#(
  parameter int unsigned XLEN = 32
);

  logic               imem_req_valid;
  logic               imem_req_ready;
  logic [XLEN-1:0]    imem_req_addr;
  logic               imem_rsp_valid;
  logic [INSTR_W-1:0] imem_rsp_data;
  logic               instr_valid;
  logic [INSTR_W-1:0] instr;
  logic [XLEN-1:0]    instr_pc;
  logic               instr_ack;
  logic               redirect;
  logic [XLEN-1:0]    redirect_pc;
  logic               halt;
  logic [15:0]        redirect_cnt;

  modport master (
    output imem_req_valid, imem_req_addr, instr_valid, instr, instr_pc, redirect_cnt,
    input  imem_req_ready, imem_rsp_valid, imem_rsp_data, instr_ack, redirect,
           redirect_pc, halt
  );

  modport slave (
    input  imem_req_valid, imem_req_addr, instr_valid, instr, instr_pc, redirect_cnt,
    output imem_req_ready, imem_rsp_valid, imem_rsp_data, instr_ack, redirect,
           redirect_pc, halt
  );

endinterface

// File: rtl/fetch_sequencer_buf2.sv
// fetch_buf2: two-entry in-order instruction/PC buffer (hold + prefetch).
//   clk, rst_n       : clock, asynchronous active-low reset
//   push/push_instr/push_pc : append an entry
//   pop              : drop the head (entry 1 shifts into entry 0)
//   flush            : invalidate both entries
//   occupancy        : number of valid entries (0..2)
//   head_valid/instr/pc : registered head entry
// Within one cycle flush/pop are applied before push, so a push lands in
// the first slot that is free after the pop.
module fetch_buf2
  import fetch_pkg::*;
#(
  parameter int unsigned XLEN = 32
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               push,
  input  logic [INSTR_W-1:0] push_instr,
  input  logic [XLEN-1:0]    push_pc,
  input  logic               pop,
  input  logic               flush,
  output logic [1:0]         occupancy,
  output logic               head_valid,
  output logic [INSTR_W-1:0] head_instr,
  output logic [XLEN-1:0]    head_pc
);

  logic [1:0]         valid_q, valid_d;
  logic [INSTR_W-1:0] instr_q [2];
  logic [INSTR_W-1:0] instr_d [2];
  logic [XLEN-1:0]    pc_q [2];
  logic [XLEN-1:0]    pc_d [2];

  always_comb begin
    valid_d = valid_q;
    instr_d = instr_q;
    pc_d    = pc_q;
    if (flush) begin
      valid_d = '0;
    end else if (pop) begin
      valid_d[0] = valid_q[1];
      instr_d[0] = instr_q[1];
      pc_d[0]    = pc_q[1];
      valid_d[1] = 1'b0;
    end
    if (push) begin
      if (!valid_d[0]) begin
        valid_d[0] = 1'b1;
        instr_d[0] = push_instr;
        pc_d[0]    = push_pc;
      end else begin
        valid_d[1] = 1'b1;
        instr_d[1] = push_instr;
        pc_d[1]    = push_pc;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= '0;
      instr_q <= '{default: '0};
      pc_q    <= '{default: '0};
    end else begin
      valid_q <= valid_d;
      instr_q <= instr_d;
      pc_q    <= pc_d;
    end
  end

  assign occupancy  = {1'b0, valid_q[0]} + {1'b0, valid_q[1]};
  assign head_valid = valid_q[0];
  assign head_instr = instr_q[0];
  assign head_pc    = pc_q[0];

endmodule

// File: rtl/fetch_sequencer.sv
// fetch_sequencer: PC sequencer and instruction-fetch controller.
//   clk   : clock, rising edge
//   rst_n : asynchronous active-low reset
//   bus   : fetch_sequencer_if.master (imem request/response, core-side
//           instruction hand-off, redirect, halt, redirect counter)
// Parameters: XLEN address width, RESET_PC first fetch address,
// BOOT_DELAY idle cycles after reset before the first request (>=1).
// Per-cycle ordering: ack/redirect, then response fill, then request issue.
module fetch_sequencer
  import fetch_pkg::*;
#(
  parameter int unsigned     XLEN       = 32,
  parameter logic [XLEN-1:0] RESET_PC   = '0,
  parameter int unsigned     BOOT_DELAY = 4
) (
  input logic              clk,
  input logic              rst_n,
  fetch_sequencer_if.master bus
);

  localparam int unsigned BW = (BOOT_DELAY > 1) ? $clog2(BOOT_DELAY) : 1;

  state_e             state;
  logic [BW-1:0]      boot_cnt;
  logic [XLEN-1:0]    fetch_pc;
  logic [1:0]         outstanding;
  logic [1:0]         kill_cnt;
  logic [15:0]        redirect_cnt;

  logic [1:0]         occupancy;
  logic               head_valid;
  logic [INSTR_W-1:0] head_instr;
  logic [XLEN-1:0]    head_pc;

  logic               ack_fire;
  logic               redirect_fire;
  logic               rsp_fire;
  logic               rsp_killed;
  logic               rsp_keep;
  logic [1:0]         kill_mid;
  logic [XLEN-1:0]    rsp_pc;
  logic [2:0]         load;
  logic               req_valid;
  logic               req_fire;

  always_comb begin
    ack_fire      = bus.instr_ack && head_valid;
    redirect_fire = ack_fire && bus.redirect;
    // Stray responses with nothing outstanding are dropped here.
    rsp_fire      = bus.imem_rsp_valid && (outstanding != 2'd0);
    // A redirect marks every outstanding request as killed before the fill
    // decision, so a response arriving in the redirect cycle is discarded.
    kill_mid      = redirect_fire ? outstanding : kill_cnt;
    rsp_killed    = rsp_fire && (kill_mid != 2'd0);
    rsp_keep      = rsp_fire && !rsp_killed;
    // Live requests are contiguous and end at fetch_pc-4, so a kept response
    // (no kills pending) belongs to fetch_pc - 4*outstanding.
    rsp_pc        = fetch_pc - XLEN'({outstanding, 2'b00});
    // Occupancy+outstanding after this cycle's ack and fill; a kept fill only
    // moves a slot from outstanding to occupancy, a killed one frees it.
    load          = {1'b0, occupancy} + {1'b0, outstanding}
                  - {2'b00, ack_fire} - {2'b00, rsp_killed};
    req_valid     = (state == RUN) && !bus.halt && !redirect_fire && (load < 3'd2);
    req_fire      = req_valid && bus.imem_req_ready;
  end

  fetch_buf2 #(
    .XLEN(XLEN)
  ) u_buf (
    .clk        (clk),
    .rst_n      (rst_n),
    .push       (rsp_keep),
    .push_instr (bus.imem_rsp_data),
    .push_pc    (rsp_pc),
    .pop        (ack_fire && !redirect_fire),
    .flush      (redirect_fire),
    .occupancy  (occupancy),
    .head_valid (head_valid),
    .head_instr (head_instr),
    .head_pc    (head_pc)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= BOOT;
      boot_cnt     <= '0;
      fetch_pc     <= RESET_PC;
      outstanding  <= '0;
      kill_cnt     <= '0;
      redirect_cnt <= '0;
    end else begin
      if (bus.imem_rsp_valid) begin
        assert (outstanding != 2'd0);
      end

      case (state)
        BOOT: begin
          if (boot_cnt == BW'(BOOT_DELAY - 1)) begin
            state <= RUN;
          end else begin
            boot_cnt <= boot_cnt + BW'(1);
          end
        end
        RUN: begin
          if (bus.halt && (outstanding == 2'd0)) begin
            state <= HALTED;
          end
        end
        HALTED: begin
          if (!bus.halt) begin
            state <= RUN;
          end
        end
        default: state <= BOOT;
      endcase

      if (redirect_fire) begin
        fetch_pc <= {bus.redirect_pc[XLEN-1:2], 2'b00};
      end else if (req_fire) begin
        fetch_pc <= fetch_pc + XLEN'(PC_STEP);
      end

      outstanding <= outstanding + {1'b0, req_fire} - {1'b0, rsp_fire};
      kill_cnt    <= kill_mid - {1'b0, rsp_killed};

      if (redirect_fire) begin
        redirect_cnt <= sat_inc16(redirect_cnt);
      end
    end
  end

  assign bus.imem_req_valid = req_valid;
  assign bus.imem_req_addr  = fetch_pc;
  assign bus.instr_valid    = head_valid;
  assign bus.instr          = head_instr;
  assign bus.instr_pc       = head_pc;
  assign bus.redirect_cnt   = redirect_cnt;

endmodule
